mem_stage_lsu: RTL

//  MEM-stage load/store unit. Consumes the EX/MEM register outputs and performs the data access on a
//  64-bit valid/ready data-memory bus: byte-enable/lane steering for stores, lane extraction and sign/zero

---
 rtl/mem_stage_lsu.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: steers store lanes and extracts/extends load lanes on a 64-bit
// valid/ready data bus, splitting 8-byte-crossing accesses into two beats and stalling the pipe.
module mem_stage_lsu #(
   parameter int XLEN    = 64,
   parameter int MTYPE_W = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               memRead_in,
   input  logic               memWrite_in,
   input  logic [MTYPE_W-1:0] memType_in,
   input  logic [XLEN-1:0]    addr_in,
   input  logic [XLEN-1:0]    writeData_in,
   output logic               stall_out,
   output logic [XLEN-1:0]    readData_out,
   output logic               readValid_out,
   output logic               bus_req_out,
   output logic               bus_we_out,
   output logic [XLEN-1:0]    bus_addr_out,
   output logic [63:0]        bus_wdata_out,
   output logic [7:0]         bus_be_out,
   input  logic               bus_ready_in,
   input  logic               bus_rvalid_in,
   input  logic [63:0]        bus_rdata_in
);

   typedef enum logic [2:0] {S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [63:0]       r_lo;
   logic [63:0]       r_hi;
   logic [XLEN-1:0]   r_rdata;

   logic              w_op;
   logic              w_store;
   logic              w_load;
   logic [1:0]        w_size;
   logic [2:0]        w_off;
   logic [3:0]        w_nbytes;
   logic              w_split;
   logic [15:0]       w_mask16;
   logic [127:0]      w_wide;
   logic [XLEN-1:0]   w_base;
   logic [XLEN-1:0]   w_ext;
   logic              w_stall;

   // Shift the two captured words down to the access offset, then truncate and extend.
   function automatic logic [63:0] load_extend(input logic [127:0] pair, input logic [2:0] off,
                                               input logic [1:0] size, input logic uns);
      logic [127:0] sh;
      logic [63:0]  res;
      sh = pair >> {off, 3'b000};
      case (size)
         2'd0:    res = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
         2'd1:    res = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
         2'd2:    res = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
         default: res = sh[63:0];
      endcase
      return res;
   endfunction

   assign w_store  = memWrite_in;
   assign w_load   = memRead_in & ~memWrite_in;
   assign w_op     = memRead_in | memWrite_in;
   assign w_size   = memType_in[1:0];
   assign w_off    = addr_in[2:0];
   assign w_nbytes = 4'd1 << w_size;
   assign w_split  = ({1'b0, w_off} + w_nbytes) > 4'd8;
   assign w_mask16 = ((16'd1 << w_nbytes) - 16'd1) << w_off;
   assign w_wide   = {64'd0, writeData_in} << {w_off, 3'b000};
   assign w_base   = addr_in & ~XLEN'(7);
   assign w_ext    = load_extend({r_hi, r_lo}, w_off, w_size, memType_in[2]);

   always_comb begin
      w_next        = r_state;
      w_stall       = 1'b0;
      bus_req_out   = 1'b0;
      bus_we_out    = 1'b0;
      bus_addr_out  = '0;
      bus_wdata_out = '0;
      bus_be_out    = '0;
      readValid_out = 1'b0;
      readData_out  = r_rdata;
      case (r_state)
         S_IDLE: begin
            w_stall = w_op;
            if (w_op) w_next = S_REQ0;
         end
         S_REQ0: begin
            w_stall       = 1'b1;
            bus_req_out   = 1'b1;
            bus_we_out    = w_store;
            bus_addr_out  = w_base;
            bus_be_out    = w_mask16[7:0];
            bus_wdata_out = w_wide[63:0];
            if (bus_ready_in) begin
               if (!w_store)     w_next = S_WAIT0;
               else if (w_split) w_next = S_REQ1;
               else              w_next = S_DONE;
            end
         end
         S_WAIT0: begin
            w_stall = 1'b1;
            if (bus_rvalid_in) w_next = w_split ? S_REQ1 : S_DONE;
         end
         S_REQ1: begin
            w_stall       = 1'b1;
            bus_req_out   = 1'b1;
            bus_we_out    = w_store;
            bus_addr_out  = w_base + XLEN'(8);
            bus_be_out    = w_mask16[15:8];
            bus_wdata_out = w_wide[127:64];
            if (bus_ready_in) w_next = w_store ? S_DONE : S_WAIT1;
         end
         S_WAIT1: begin
            w_stall = 1'b1;
            if (bus_rvalid_in) w_next = S_DONE;
         end
         S_DONE: begin
            w_next = S_IDLE;
            if (w_load) begin
               readValid_out = 1'b1;
               readData_out  = w_ext;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Stall is combinational from the op inputs in IDLE, so mask it while reset is held.
   assign stall_out = w_stall & reset;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_lo    <= '0;
         r_hi    <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_WAIT0 && bus_rvalid_in) r_lo <= bus_rdata_in;
         if (r_state == S_WAIT1 && bus_rvalid_in) r_hi <= bus_rdata_in;
         if (r_state == S_DONE && w_load)         r_rdata <= w_ext;
      end
   end

endmodule
